waveform_frame_sequencer: RTL

WAVEFORM_FRAME_SEQUENCER -- requirements
Module: waveform_frame_sequencer

---
 rtl/waveform_frame_sequencer_if.sv | 23 ++
 rtl/waveform_frame_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/waveform_frame_sequencer_if.sv
// Sample-FIFO read port and 1-bit framebuffer write port of the waveform frame sequencer.
// The master side pops samples and drives the framebuffer; the slave side is the FIFO and memory.
interface waveform_frame_sequencer_if #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int ADDR_WIDTH   = 19
);
  logic signed [SAMPLE_WIDTH-1:0] mono_sample;
  logic                           fifo_empty;
  logic                           fifo_rd_en;
  logic        [ADDR_WIDTH-1:0]   pixel_addr;
  logic                           pixel_data;
  logic                           pixel_wr_en;

  modport master (
    input  mono_sample, fifo_empty,
    output fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
  );

  modport slave (
    output mono_sample, fifo_empty,
    input  fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
  );
endinterface

// File: rtl/waveform_frame_sequencer.sv
// Draws one sample per column as a 1-bit trace: erase the old pixel, then draw the new one.
// Latency: 4 cycles per column (FETCH, CAPTURE, ERASE, DRAW); an empty FIFO stalls FETCH indefinitely.
module waveform_frame_sequencer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int SAMPLE_WIDTH  = 24,
  parameter int ADDR_WIDTH    = 19,
  parameter int SHIFT         = 15
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        frame_pulse,
  waveform_frame_sequencer_if.master  io,
  output logic                        busy,
  output logic                        frame_overrun
);

  localparam int X_W   = $clog2(SCREEN_WIDTH);
  localparam int Y_W   = $clog2(SCREEN_HEIGHT);
  localparam int TOTAL = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int D_W   = SAMPLE_WIDTH + 2;

  localparam logic [ADDR_WIDTH-1:0] W_A       = ADDR_WIDTH'(SCREEN_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [X_W-1:0]        X_LAST    = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0]        CENTER_Y  = Y_W'(SCREEN_HEIGHT / 2 - 1);
  localparam logic [Y_W-1:0]        Y_MAX     = Y_W'(SCREEN_HEIGHT - 1);
  localparam logic signed [D_W-1:0] CENTER_S  = D_W'(SCREEN_HEIGHT / 2 - 1);
  localparam logic signed [D_W-1:0] Y_MAX_S   = D_W'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {INIT, IDLE, FETCH, CAPTURE, ERASE, DRAW} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   init_addr, init_addr_n;
  logic                    init_last, init_last_n;
  logic [X_W-1:0]          x, x_n;
  logic [Y_W-1:0]          y_q, y_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic                    data_n, wr_n, overrun_n, rd_en;

  logic [Y_W-1:0]          prev_y [SCREEN_WIDTH];
  logic                    prev_we;
  logic [X_W-1:0]          prev_wa;
  logic [Y_W-1:0]          prev_wd;

  logic signed [SAMPLE_WIDTH-1:0] shifted;
  logic signed [D_W-1:0]          y_diff;
  logic [Y_W-1:0]                 y_clamp;

  // Constant multiplier: for 640 columns this reduces to y*512 + y*128 shift-adds.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [Y_W-1:0] yy,
                                                    input logic [X_W-1:0] xx);
    return ADDR_WIDTH'(yy) * W_A + ADDR_WIDTH'(xx);
  endfunction

  assign shifted = io.mono_sample >>> SHIFT;
  assign y_diff  = CENTER_S - $signed({{2{shifted[SAMPLE_WIDTH-1]}}, shifted});

  always_comb begin
    y_clamp = y_diff[Y_W-1:0];
    if (y_diff[D_W-1])
      y_clamp = '0;
    else if (y_diff > Y_MAX_S)
      y_clamp = Y_MAX;
  end

  always_comb begin
    state_n     = state;
    init_addr_n = init_addr;
    init_last_n = init_last;
    x_n         = x;
    y_n         = y_q;
    addr_n      = io.pixel_addr;
    data_n      = 1'b0;
    wr_n        = 1'b0;
    rd_en       = 1'b0;
    prev_we     = 1'b0;
    prev_wa     = x;
    prev_wd     = y_q;
    overrun_n   = frame_overrun;

    case (state)
      INIT: begin
        // First INIT cycle after reset carries no strobe, so the last write lands while still busy.
        if (init_last) begin
          state_n = IDLE;
        end else begin
          addr_n      = init_addr;
          wr_n        = 1'b1;
          init_addr_n = init_addr + 1'b1;
          if (init_addr == LAST_A)
            init_last_n = 1'b1;
          if (init_addr < W_A) begin
            prev_we = 1'b1;
            prev_wa = init_addr[X_W-1:0];
            prev_wd = CENTER_Y;
          end
        end
      end
      IDLE: begin
        if (frame_pulse) begin
          state_n = FETCH;
          x_n     = '0;
        end
      end
      FETCH: begin
        if (!io.fifo_empty) begin
          rd_en   = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        y_n     = y_clamp;
        addr_n  = addr_of(prev_y[x], x);
        wr_n    = 1'b1;
        state_n = ERASE;
      end
      ERASE: begin
        addr_n  = addr_of(y_q, x);
        data_n  = 1'b1;
        wr_n    = 1'b1;
        prev_we = 1'b1;
        state_n = DRAW;
      end
      DRAW: begin
        if (x == X_LAST) begin
          state_n = IDLE;
        end else begin
          x_n     = x + 1'b1;
          state_n = FETCH;
        end
      end
      default: state_n = INIT;
    endcase

    if (frame_pulse && (state == FETCH || state == CAPTURE || state == ERASE || state == DRAW))
      overrun_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= INIT;
      init_addr      <= '0;
      init_last      <= 1'b0;
      x              <= '0;
      y_q            <= '0;
      io.pixel_addr  <= '0;
      io.pixel_data  <= 1'b0;
      io.pixel_wr_en <= 1'b0;
      frame_overrun  <= 1'b0;
    end else begin
      state          <= state_n;
      init_addr      <= init_addr_n;
      init_last      <= init_last_n;
      x              <= x_n;
      y_q            <= y_n;
      io.pixel_addr  <= addr_n;
      io.pixel_data  <= data_n;
      io.pixel_wr_en <= wr_n;
      frame_overrun  <= overrun_n;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && prev_we)
      prev_y[prev_wa] <= prev_wd;
  end

  assign io.fifo_rd_en = rd_en;
  assign busy          = (state != IDLE);

endmodule
